// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI MMU page-table walker:
// descriptor type codes, page sizes, fault status values and the TLB refill record.
package arm7tdmi_pkg;

    typedef enum logic [1:0] {
        L1_FAULT    = 2'b00,
        L1_COARSE   = 2'b01,
        L1_SECTION  = 2'b10,
        L1_RESERVED = 2'b11
    } l1_type_e;

    // Tiny pages (11) are not supported and decode as a translation fault.
    typedef enum logic [1:0] {
        L2_FAULT = 2'b00,
        L2_LARGE = 2'b01,
        L2_SMALL = 2'b10,
        L2_TINY  = 2'b11
    } l2_type_e;

    typedef enum logic [1:0] {
        SIZE_1M  = 2'b00,
        SIZE_64K = 2'b01,
        SIZE_4K  = 2'b10
    } page_size_e;

    localparam logic [3:0] FSR_NONE     = 4'h0;
    localparam logic [3:0] FSR_L1_TRANS = 4'h5;
    localparam logic [3:0] FSR_L2_TRANS = 4'h7;
    localparam logic [3:0] FSR_L1_ABORT = 4'hC;
    localparam logic [3:0] FSR_L2_ABORT = 4'hE;

    typedef enum logic [2:0] {
        IDLE,
        L1_RD,
        L2_RD,
        RESP,
        DRAIN
    } ptw_state_e;

    typedef struct packed {
        logic [19:0] pbase;
        page_size_e  size;
        logic        global;
        logic        c;
        logic        b;
        logic [1:0]  ap;
        logic [3:0]  domain;
        logic [7:0]  asid;
        logic [31:0] vaddr;
    } tlb_refill_t;

endpackage

// File: rtl/arm7tdmi_ptw_decode.sv
// Combinational L1/L2 descriptor decoder; turns one fetched descriptor into a
// refill entry, a fault record, or a request to continue into the coarse table.
module arm7tdmi_ptw_decode
    import arm7tdmi_pkg::*;
(
    input  logic        level2,
    input  logic [31:0] desc,
    input  logic        abort,
    input  logic [3:0]  l1_domain,
    input  logic [31:0] vaddr,
    input  logic [7:0]  asid,
    output tlb_refill_t entry,
    output logic        next_l2,
    output logic        fault,
    output logic [3:0]  fsr
);

    logic unused_desc;
    assign unused_desc = desc[9];

    // NOTE: every output gets a default before the case split; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        entry       = '0;
        entry.vaddr = vaddr;
        entry.asid  = asid;
        next_l2     = 1'b0;
        fault       = 1'b0;
        fsr         = FSR_NONE;
        if (!level2) begin
            entry.domain = desc[8:5];
            if (abort) begin
                fault = 1'b1;
                fsr   = FSR_L1_ABORT;
            end else begin
                case (l1_type_e'(desc[1:0]))
                    L1_SECTION: begin
                        entry.pbase  = {desc[31:20], 8'h00};
                        entry.size   = SIZE_1M;
                        entry.b      = desc[2];
                        entry.c      = desc[3];
                        entry.global = desc[4];
                        entry.ap     = desc[11:10];
                    end
                    L1_COARSE: next_l2 = 1'b1;
                    default: begin
                        fault = 1'b1;
                        fsr   = FSR_L1_TRANS;
                    end
                endcase
            end
        end else begin
            entry.domain = l1_domain;
            entry.b      = desc[2];
            entry.c      = desc[3];
            entry.ap     = desc[5:4];
            entry.global = desc[11];
            if (abort) begin
                fault = 1'b1;
                fsr   = FSR_L2_ABORT;
            end else begin
                case (l2_type_e'(desc[1:0]))
                    L2_LARGE: begin
                        entry.pbase = {desc[31:16], 4'h0};
                        entry.size  = SIZE_64K;
                    end
                    L2_SMALL: begin
                        entry.pbase = desc[31:12];
                        entry.size  = SIZE_4K;
                    end
                    default: begin
                        fault = 1'b1;
                        fsr   = FSR_L2_TRANS;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/arm7tdmi_ptw.sv
// Hardware page-table walker: fetches L1 (and coarse L2) descriptors for a TLB
// miss and returns one refill entry or fault record to the MMU.
module arm7tdmi_ptw
    import arm7tdmi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  walk_req,
    output logic                  walk_ready,
    input  logic [ADDR_WIDTH-1:0] walk_vaddr,
    input  logic [7:0]            walk_asid,
    input  logic [ADDR_WIDTH-1:0] ttb_base,
    input  logic                  walk_cancel,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    input  logic                  mem_abort,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ADDR_WIDTH-1:0] res_vaddr,
    output logic [7:0]            res_asid,
    output logic [19:0]           res_pbase,
    output logic [1:0]            res_size,
    output logic                  res_global,
    output logic                  res_c,
    output logic                  res_b,
    output logic [1:0]            res_ap,
    output logic [3:0]            res_domain,
    output logic                  res_fault,
    output logic [3:0]            res_fsr,
    output logic [31:0]           walk_count,
    output logic [31:0]           fault_count
);

    ptw_state_e  state_q, state_d;
    logic [31:0] vaddr_q;
    logic [7:0]  asid_q;
    logic [17:0] ttb_q;
    logic [21:0] l2_base_q;
    logic [3:0]  domain_q;
    logic        l2_phase_q;
    tlb_refill_t entry_q;
    logic        fault_q;
    logic [3:0]  fsr_q;

    logic        accept, to_l2, done, count_fault;
    tlb_refill_t dec_entry;
    logic        dec_next_l2, dec_fault;
    logic [3:0]  dec_fsr;

    logic unused_ttb;
    assign unused_ttb = ^ttb_base[13:0];

    arm7tdmi_ptw_decode u_decode (
        .level2    (l2_phase_q),
        .desc      (mem_rdata),
        .abort     (mem_abort),
        .l1_domain (domain_q),
        .vaddr     (vaddr_q),
        .asid      (asid_q),
        .entry     (dec_entry),
        .next_l2   (dec_next_l2),
        .fault     (dec_fault),
        .fsr       (dec_fsr)
    );

    always_comb begin
        state_d     = state_q;
        walk_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        res_valid   = 1'b0;
        accept      = 1'b0;
        to_l2       = 1'b0;
        done        = 1'b0;
        count_fault = 1'b0;
        case (state_q)
            IDLE: begin
                walk_ready = 1'b1;
                if (walk_req) begin
                    accept  = 1'b1;
                    state_d = L1_RD;
                end
            end
            L1_RD, L2_RD, DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = l2_phase_q ? {l2_base_q, vaddr_q[19:12], 2'b00}
                                      : {ttb_q, vaddr_q[31:20], 2'b00};
                // A cancelled walk still finishes its bus transfer before going idle.
                if (state_q == DRAIN || walk_cancel) begin
                    if (mem_ready) state_d = IDLE;
                    else           state_d = DRAIN;
                end else if (mem_ready) begin
                    if (dec_next_l2 && !l2_phase_q) begin
                        to_l2   = 1'b1;
                        state_d = L2_RD;
                    end else begin
                        done    = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (walk_cancel) begin
                    state_d = IDLE;
                end else if (res_ready) begin
                    count_fault = fault_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    // NOTE: datapath registers are reset as well, since the result outputs
    // must read zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vaddr_q     <= '0;
            asid_q      <= '0;
            ttb_q       <= '0;
            l2_base_q   <= '0;
            domain_q    <= '0;
            l2_phase_q  <= 1'b0;
            entry_q     <= '0;
            fault_q     <= 1'b0;
            fsr_q       <= '0;
            walk_count  <= '0;
            fault_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                vaddr_q    <= walk_vaddr;
                asid_q     <= walk_asid;
                ttb_q      <= ttb_base[31:14];
                l2_phase_q <= 1'b0;
                walk_count <= walk_count + 32'd1;
            end
            if (to_l2) begin
                l2_base_q  <= mem_rdata[31:10];
                domain_q   <= mem_rdata[8:5];
                l2_phase_q <= 1'b1;
            end
            if (done) begin
                entry_q <= dec_entry;
                fault_q <= dec_fault;
                fsr_q   <= dec_fsr;
            end
            if (count_fault) fault_count <= fault_count + 32'd1;
        end
    end

    assign res_vaddr  = entry_q.vaddr;
    assign res_asid   = entry_q.asid;
    assign res_pbase  = entry_q.pbase;
    assign res_size   = entry_q.size;
    assign res_global = entry_q.global;
    assign res_c      = entry_q.c;
    assign res_b      = entry_q.b;
    assign res_ap     = entry_q.ap;
    assign res_domain = entry_q.domain;
    assign res_fault  = fault_q;
    assign res_fsr    = fsr_q;

endmodule
